rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the multi-cycle core's register file. It shares the file's single write port (data_in/Rd/we) between two producers, the ALU result path and the load unit, using round-robin arbitration and a registered output stage. An optional busy-bit scoreboard tracks destination registers with writes still in flight, so the control FSM can stall dependent reads.

---
 rtl/rf_ctrl_pkg.sv | 13 +
 rtl/rf_wb_arbiter_if.sv | 38 +++
 rtl/rf_wb_arbiter_rr_arb2.sv | 30 +++
 rtl/rf_wb_arbiter.sv | 93 +++++++++
 tb/tb_rf_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write-back path.
package rf_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_AW       = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: two producer request channels and the register-file write port.
// Handshake: a request transfers in the cycle where valid and ready are both high;
// ready depends combinationally on valid, and rd/data must hold while valid && !ready.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32
);
  import rf_ctrl_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              mem_ready;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_data;
  wb_src_t           rf_src;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  rf_we, rf_rd, rf_data, rf_src
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output rf_we, rf_rd, rf_data, rf_src
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = ALU, bit 1 = MEM.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  wb_src_t last_grant;

  always_comb begin
    gnt = req;
    // On contention the source that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = (last_grant == SRC_MEM) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_MEM;
    end else if (accept) begin
      last_grant <= gnt[1] ? SRC_MEM : SRC_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with registered output and optional busy-bit
// scoreboard (enabled by defining RF_WB_SCOREBOARD_EN).
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [NREG-1:0]   busy,
  output logic              hazard
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;
  wb_src_t           sel_src;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  // Requests are masked during reset so neither producer sees ready.
  assign req    = {bus.mem_valid, bus.alu_valid} & {2{~rst}};
  assign accept = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.mem_ready = gnt[1];

  assign sel_src  = gnt[1] ? SRC_MEM : SRC_ALU;
  assign sel_rd   = gnt[1] ? bus.mem_rd : bus.alu_rd;
  assign sel_data = gnt[1] ? bus.mem_data : bus.alu_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we   <= 1'b0;
      bus.rf_rd   <= '0;
      bus.rf_data <= '0;
      bus.rf_src  <= SRC_ALU;
    end else begin
      // x0 writes still consume the grant but never reach the file.
      bus.rf_we <= accept && (sel_rd != '0);
      if (accept) begin
        bus.rf_rd   <= sel_rd;
        bus.rf_data <= sel_data;
        bus.rf_src  <= sel_src;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_rd != '0)) set_mask[issue_rd] = 1'b1;
    if (bus.rf_we) clr_mask[bus.rf_rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & {{(NREG-1){1'b1}}, 1'b0};
    end
  end

  assign busy   = busy_q;
  assign hazard = busy_q[rs1] | busy_q[rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_rd, rs1, rs2};
  assign busy      = '0;
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table, hand sequences and a random phase,
// with expected register-file writes queued at acceptance and checked one cycle later.
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;

  localparam int W = 39;  // {we, rd[4:0], data[31:0], src}
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ar;
    logic        mr;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd    = '0;
  logic [4:0]  rs1         = '0;
  logic [4:0]  rs2         = '0;
  logic [31:0] busy;
  logic        hazard;

  rf_wb_arbiter_if #(.XLEN(32)) b ();

  rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (b),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy        (busy),
    .hazard      (hazard)
  );

  a_alu_stable: assert property (@(posedge clk) disable iff (rst)
    (b.alu_valid && !b.alu_ready) |=> ($stable(b.alu_rd) && $stable(b.alu_data)))
    else $error("FAIL alu_stable: rd/data changed while waiting");
  a_mem_stable: assert property (@(posedge clk) disable iff (rst)
    (b.mem_valid && !b.mem_ready) |=> ($stable(b.mem_rd) && $stable(b.mem_data)))
    else $error("FAIL mem_stable: rd/data changed while waiting");

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [31:0]  model_busy = '0;
  logic [W-1:0] cur_item   = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                              input logic iv, input logic [4:0] ird,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic ar, input logic mr);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.iv = iv; v.ird = ird; v.rs1 = r1; v.rs2 = r2;
    v.ar = ar; v.mr = mr;
    return v;
  endfunction

  // driver: one cycle per vector
  task automatic step(input vec_t v, input string name);
    logic [31:0]  set_m;
    logic [31:0]  clr_m;
    logic [W-1:0] it;
    logic [31:0]  exp_busy;
    @(negedge clk);
    b.alu_valid = v.av; b.alu_rd = v.ard; b.alu_data = v.adata;
    b.mem_valid = v.mv; b.mem_rd = v.mrd; b.mem_data = v.mdata;
    issue_valid = v.iv; issue_rd = v.ird; rs1 = v.rs1; rs2 = v.rs2;
    #1;
    exp_busy = SB_EN ? model_busy : 32'h0;
    check({name, "_alu_ready"}, b.alu_ready, v.ar);
    check({name, "_mem_ready"}, b.mem_ready, v.mr);
    check({name, "_busy"}, busy, exp_busy);
    check({name, "_hazard"}, hazard, exp_busy[v.rs1] | exp_busy[v.rs2]);
    if (v.ar) exp_q.push_back({(v.ard != 5'd0), v.ard, v.adata, 1'b0});
    else if (v.mr) exp_q.push_back({(v.mrd != 5'd0), v.mrd, v.mdata, 1'b1});
    set_m = '0;
    clr_m = '0;
    if (v.iv) set_m[v.ird] = 1'b1;
    if (cur_item[W-1]) clr_m[cur_item[37:33]] = 1'b1;
    @(posedge clk);
    #1;
    model_busy = ((model_busy & ~clr_m) | set_m) & 32'hFFFF_FFFE;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      check({name, "_rf_we"}, b.rf_we, it[W-1]);
      if (it[W-1]) begin
        check({name, "_rf_rd"}, b.rf_rd, it[37:33]);
        check({name, "_rf_data"}, b.rf_data, it[32:1]);
        check({name, "_rf_src"}, b.rf_src, it[0]);
      end
      cur_item = it;
    end else begin
      check({name, "_rf_we_idle"}, b.rf_we, 1'b0);
      cur_item = '0;
    end
  endtask

  // reset with both producers requesting; ready must stay low throughout
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    b.alu_valid = 1'b1; b.mem_valid = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    check({name, "_alu_ready_rst"}, b.alu_ready, 1'b0);
    check({name, "_mem_ready_rst"}, b.mem_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_rf_we_rst"}, b.rf_we, 1'b0);
    check({name, "_rf_rd_rst"}, b.rf_rd, 5'd0);
    check({name, "_rf_data_rst"}, b.rf_data, 32'd0);
    check({name, "_rf_src_rst"}, b.rf_src, 1'b0);
    check({name, "_busy_rst"}, busy, 32'd0);
    @(negedge clk);
    b.alu_valid = 1'b0; b.mem_valid = 1'b0; issue_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    model_busy = '0;
    cur_item = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  vec_t tbl[15];
  vec_t v;
  logic lg;       // 1 = MEM granted most recently
  logic hold_a;
  logic hold_m;

  initial begin
    b.alu_valid = 1'b0; b.alu_rd = '0; b.alu_data = '0;
    b.mem_valid = 1'b0; b.mem_rd = '0; b.mem_data = '0;

    //            av ard   adata          mv mrd   mdata          iv ird  rs1  rs2  ar mr
    tbl[0]  = mk(1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    tbl[1]  = mk(1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    tbl[2]  = mk(1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    tbl[3]  = mk(1, 5'd1, 32'h1111_0001, 1, 5'd2, 32'h2222_0002, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    tbl[4]  = mk(0, 5'd1, 32'h1111_0001, 0, 5'd2, 32'h2222_0002, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    tbl[5]  = mk(1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0, 1, 0);
    tbl[6]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0, 0, 0);
    tbl[7]  = mk(0, 5'd0, 32'h0,         1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    tbl[8]  = mk(0, 5'd0, 32'h0,         1, 5'd9, 32'hCAFE_0009, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    tbl[9]  = mk(1, 5'd3, 32'hA0A0_0003, 1, 5'd4, 32'hB0B0_0004, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    tbl[10] = mk(1, 5'd3, 32'hA0A0_0003, 1, 5'd4, 32'hB0B0_0004, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    tbl[11] = mk(0, 5'd3, 32'hA0A0_0003, 1, 5'd10, 32'h0BAD_000A, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    tbl[12] = mk(1, 5'd11, 32'h0000_001B, 1, 5'd12, 32'h0000_001C, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    tbl[13] = mk(0, 5'd11, 32'h0000_001B, 1, 5'd12, 32'h0000_001C, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    tbl[14] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0, 0, 0);

    do_reset("por");

    for (int i = 0; i < 15; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // busy-bit sequence on register 7
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd0, 0, 0), "sb_issue");
    check("sb_busy7_after_issue", busy[7], SB_EN);
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0, 0, 0), "sb_wait2");
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0, 0, 0), "sb_wait3");
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0, 0, 0), "sb_wait4");
    step(mk(1, 5'd7, 32'h0000_0077, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0, 1, 0), "sb_wb");
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0, 0, 0), "sb_wb_fire");
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0, 0, 0), "sb_cleared");
    step(mk(1, 5'd7, 32'h0000_0088, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 5'd7, 1, 0), "sb_iss_wb");
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 5'd7, 0, 0), "sb_set_wins");
    check("sb_busy7_set_wins", busy[7], SB_EN);
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd7, 0, 0), "sb_hold");
    step(mk(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 5'd7, 0, 1), "sb_x0");
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0), "sb_x0_after");
    check("sb_x0_busy_unchanged", busy, SB_EN ? 32'h0000_0080 : 32'h0);

    // reset in the cycle after an acceptance
    step(mk(1, 5'd13, 32'h0000_000D, 0, 5'd0, 32'h0, 1, 5'd13, 5'd0, 5'd0, 1, 0), "mf_accept");
    do_reset("mf");
    step(mk(1, 5'd20, 32'h0000_0014, 1, 5'd21, 32'h0000_0015, 0, 5'd0, 5'd0, 5'd0, 1, 0), "mf_cont1");
    step(mk(1, 5'd20, 32'h0000_0014, 1, 5'd21, 32'h0000_0015, 0, 5'd0, 5'd0, 5'd0, 0, 1), "mf_cont2");
    step(mk(1, 5'd20, 32'h0000_0014, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1, 0), "mf_drain");

    // random phase against a tiny round-robin model
    lg = 1'b0;
    hold_a = 1'b0;
    hold_m = 1'b0;
    v = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      if (!hold_a) begin
        v.av = 1'($urandom_range(0, 1));
        v.ard = 5'($urandom_range(0, 31));
        v.adata = $urandom;
      end
      if (!hold_m) begin
        v.mv = 1'($urandom_range(0, 1));
        v.mrd = 5'($urandom_range(0, 31));
        v.mdata = $urandom;
      end
      v.iv = 1'($urandom_range(0, 1));
      v.ird = 5'($urandom_range(0, 31));
      v.rs1 = 5'($urandom_range(0, 31));
      v.rs2 = 5'($urandom_range(0, 31));
      v.ar = v.av && (!v.mv || lg);
      v.mr = v.mv && (!v.av || !lg);
      step(v, $sformatf("rand%0d", i));
      if (v.ar) lg = 1'b0;
      else if (v.mr) lg = 1'b1;
      hold_a = v.av && !v.ar;
      hold_m = v.mv && !v.mr;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
